// File: rtl/freq_pkg.sv
// Shared constants and types for the frequency meter: ratio codes, the
// divider periods they correspond to, and the measurement FSM states.
package freq_pkg;

  localparam logic [1:0] RATIO_OTHER = 2'd0;
  localparam logic [1:0] RATIO_2     = 2'd1;
  localparam logic [1:0] RATIO_10    = 2'd2;
  localparam logic [1:0] RATIO_100   = 2'd3;

  localparam logic [31:0] PERIOD_DIV2   = 32'd2;
  localparam logic [31:0] PERIOD_DIV10  = 32'd10;
  localparam logic [31:0] PERIOD_DIV100 = 32'd100;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_e;

  // Map a measured period onto the divider ratio it matches exactly.
  function automatic logic [1:0] classify_period(input logic [31:0] p);
    logic [1:0] r;
    case (p)
      PERIOD_DIV2:   r = RATIO_2;
      PERIOD_DIV10:  r = RATIO_10;
      PERIOD_DIV100: r = RATIO_100;
      default:       r = RATIO_OTHER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Three-flop synchronizer for an asynchronous input followed by a
// rising-edge detector on the two settled stages.
module sync_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain; s3 only serves as the delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Measures the rising-to-rising period of a slow input in system clocks,
// classifies it against the divider ratios and reports lock / loss of signal.
module freq_meter
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_PERIOD = 1000,
  parameter int unsigned LOCK_N     = 4
) (
  input  logic             CLK_in,
  input  logic             RST_N,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [1:0]       ratio,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned     MC_W      = (LOCK_N > 2) ? $clog2(LOCK_N) : 1;
  localparam logic [MC_W-1:0] MATCH_CAP = MC_W'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rise_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ref_q;
  logic [MC_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0] period_q;
  logic             vld_q;
  logic [1:0]       ratio_q, ratio_d;
  logic             locked_q;
  logic             timeout_q;
  logic             at_max_s;

  sync_rise u_sync (
    .clk_i  (CLK_in),
    .rst_ni (RST_N),
    .sig_i  (sig_in),
    .rise_o (rise_s)
  );

  // Next match count and ratio code for the measurement that would complete now.
  always_comb begin
    at_max_s = (cnt_q == CNT_MAX);
    ratio_d  = classify_period(32'(cnt_q));
    if (cnt_q == ref_q) begin
      match_d = (match_q == MATCH_CAP) ? match_q : match_q + MC_W'(1);
    end else begin
      match_d = '0;
    end
  end

  // Measurement FSM; ref_q is cleared on timeout so the first period after
  // re-acquisition can never count as a match even though period_q holds.
  always_ff @(posedge CLK_in or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ACQUIRE;
      cnt_q     <= '0;
      ref_q     <= '0;
      match_q   <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      ratio_q   <= RATIO_OTHER;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ACQUIRE: begin
          if (rise_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= TRACK;
          end else begin
            cnt_q <= '0;
          end
        end
        TRACK: begin
          if (rise_s) begin
            period_q  <= cnt_q;
            vld_q     <= 1'b1;
            ratio_q   <= ratio_d;
            timeout_q <= 1'b0;
            ref_q     <= cnt_q;
            match_q   <= match_d;
            locked_q  <= (match_d == MATCH_CAP);
            cnt_q     <= CNT_ONE;
          end else if (at_max_s) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            match_q   <= '0;
            ref_q     <= '0;
            cnt_q     <= '0;
            state_q   <= ACQUIRE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ACQUIRE;
        end
      endcase
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign ratio      = ratio_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: table of constant-period streams plus
// hand-written sequences for mismatch, timeout, max period and reset.
module tb_freq_meter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             RST_N = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic [1:0]       ratio;
  logic             locked;
  logic             timeout;

  freq_meter #(.CNT_W(CNT_W), .MAX_PERIOD(1000), .LOCK_N(4)) dut (
    .CLK_in     (clk),
    .RST_N      (RST_N),
    .sig_in     (sig_in),
    .period     (period),
    .period_vld (period_vld),
    .ratio      (ratio),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   per;
    int   rat;
    logic lk;
    logic to;
    int   cyc;
  } cap_t;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_per;
    int exp_rat;
  } vec_t;

  cap_t caps[$];
  int   to_rises[$];
  int   cyc = 0;
  logic to_prev = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every measurement pulse and every rising edge of timeout.
  always @(negedge clk) begin
    if (RST_N && period_vld) caps.push_back('{int'(period), int'(ratio), locked, timeout, cyc});
    if (timeout && !to_prev) to_rises.push_back(cyc);
    to_prev <= timeout;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    hold(1'b0, 3);
    chk("rst_period", int'(period), 0);
    chk("rst_vld", int'(period_vld), 0);
    chk("rst_ratio", int'(ratio), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    RST_N = 1'b1;
    hold(1'b0, 4);
  endtask

  vec_t vecs[5];

  initial begin
    int base;
    int tb0;
    int n;

    vecs[0] = '{1, 1, 6, 2, 1};
    vecs[1] = '{5, 5, 5, 10, 2};
    vecs[2] = '{50, 50, 4, 100, 3};
    vecs[3] = '{3, 4, 5, 7, 0};
    vecs[4] = '{500, 500, 2, 1000, 0};

    @(posedge clk);
    #1;

    // Constant-period streams: n measurements from n+1 rising edges.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      base = caps.size();
      for (int k = 0; k <= vecs[v].n; k++) begin
        hold(1'b1, vecs[v].hi);
        hold(1'b0, vecs[v].lo);
      end
      hold(1'b0, 5);
      n = caps.size() - base;
      chk($sformatf("v%0d_count", v), n, vecs[v].n);
      for (int i = 0; i < n; i++) begin
        chk($sformatf("v%0d_m%0d_period", v, i), caps[base+i].per, vecs[v].exp_per);
        chk($sformatf("v%0d_m%0d_ratio", v, i), caps[base+i].rat, vecs[v].exp_rat);
        chk($sformatf("v%0d_m%0d_locked", v, i), int'(caps[base+i].lk), (i >= 3) ? 1 : 0);
        chk($sformatf("v%0d_m%0d_timeout", v, i), int'(caps[base+i].to), 0);
        if (i > 0)
          chk($sformatf("v%0d_m%0d_spacing", v, i), caps[base+i].cyc - caps[base+i-1].cyc, vecs[v].exp_per);
      end
    end

    // Periods 10,10,10,11: only three matches, never locks.
    do_reset();
    base = caps.size();
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    hold(1'b1, 5);
    hold(1'b0, 6);
    hold(1'b1, 5);
    hold(1'b0, 5);
    n = caps.size() - base;
    chk("mm_count", n, 4);
    for (int i = 0; i < n; i++)
      chk($sformatf("mm_m%0d_locked", i), int'(caps[base+i].lk), 0);
    chk("mm_last_period", int'(period), 11);
    chk("mm_last_ratio", int'(ratio), 0);

    // Locked 100-cycle stream, then input stuck low.
    do_reset();
    base = caps.size();
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 50);
      hold(1'b0, 50);
    end
    hold(1'b1, 50);
    chk("to_pre_count", caps.size() - base, 5);
    chk("to_pre_locked", int'(locked), 1);
    tb0 = to_rises.size();
    hold(1'b0, 1010);
    chk("to_seen", to_rises.size() - tb0, 1);
    if (to_rises.size() > tb0 && caps.size() > base)
      chk("to_delay", to_rises[to_rises.size()-1] - caps[caps.size()-1].cyc, 1000);
    chk("to_flag", int'(timeout), 1);
    chk("to_locked", int'(locked), 0);
    chk("to_period_hold", int'(period), 100);
    chk("to_ratio_hold", int'(ratio), 3);
    base = caps.size();
    hold(1'b1, 50);
    hold(1'b0, 50);
    chk("restart_first_novld", caps.size() - base, 0);
    chk("restart_first_sticky", int'(timeout), 1);
    hold(1'b1, 50);
    hold(1'b0, 5);
    chk("restart_count", caps.size() - base, 1);
    if (caps.size() > base) begin
      chk("restart_period", caps[base].per, 100);
      chk("restart_to_at_vld", int'(caps[base].to), 0);
      chk("restart_locked", int'(caps[base].lk), 0);
    end
    chk("restart_timeout", int'(timeout), 0);

    // Period 1001 exceeds the limit: timeout, no measurement.
    do_reset();
    base = caps.size();
    hold(1'b1, 500);
    hold(1'b0, 501);
    hold(1'b1, 10);
    hold(1'b0, 5);
    chk("p1001_count", caps.size() - base, 0);
    chk("p1001_timeout", int'(timeout), 1);
    chk("p1001_period", int'(period), 0);

    // Asynchronous reset in mid-period while locked.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    hold(1'b1, 3);
    chk("ar_pre_locked", int'(locked), 1);
    chk("ar_pre_period", int'(period), 10);
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar_period", int'(period), 0);
    chk("ar_vld", int'(period_vld), 0);
    chk("ar_ratio", int'(ratio), 0);
    chk("ar_locked", int'(locked), 0);
    chk("ar_timeout", int'(timeout), 0);
    sig_in = 1'b0;
    @(posedge clk);
    #1;
    hold(1'b0, 2);
    RST_N = 1'b1;
    hold(1'b0, 4);
    base = caps.size();
    hold(1'b1, 5);
    hold(1'b0, 5);
    chk("ar_first_edge_novld", caps.size() - base, 0);
    hold(1'b1, 5);
    hold(1'b0, 5);
    chk("ar_count", caps.size() - base, 1);
    if (caps.size() > base) begin
      chk("ar_meas_period", caps[base].per, 10);
      chk("ar_meas_ratio", caps[base].rat, 2);
      chk("ar_meas_locked", int'(caps[base].lk), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
